// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU/HI-LO function codes and multiply/divide state encoding.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
//
// Contents:
//   ADD/SUB/AND/OR/SLT   - ALU funct codes
//   MULTU/DIVU/MFHI/MFLO - HI/LO unit funct codes
//   md_state_t           - multiply/divide controller states
//   is_md_start()        - true for funct codes that launch a HI/LO operation
package mips_pkg;

  localparam logic [5:0] ADD   = 6'd32;
  localparam logic [5:0] SUB   = 6'd34;
  localparam logic [5:0] AND   = 6'd36;
  localparam logic [5:0] OR    = 6'd37;
  localparam logic [5:0] SLT   = 6'd42;

  localparam logic [5:0] MFHI  = 6'd16;
  localparam logic [5:0] MFLO  = 6'd18;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] DIVU  = 6'd27;

  localparam int unsigned MD_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic is_md_start(input logic [5:0] fn);
    return (fn == MULTU) || (fn == DIVU);
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the controller decides when to register it.
//
// Ports:
//   div_mode  in  1  - 0: multiply step, 1: divide step
//   work      in  65 - multiply: {carry, acc, mplr}; divide: {unused, rem, quo}
//   operand   in  32 - multiplicand or divisor
//   work_nxt  out 65 - working register after this iteration
module multdiv_step
  import mips_pkg::*;
(
  input  logic        div_mode,
  input  logic [64:0] work,
  input  logic [31:0] operand,
  output logic [64:0] work_nxt
);

  logic [31:0] acc;
  logic [31:0] mplr;
  logic [31:0] rem_sh;
  logic [31:0] quo_sh;
  logic [32:0] add_a;
  logic [32:0] add_b;
  logic        cin;
  logic [32:0] sum;

  always_comb begin
    acc    = work[63:32];
    mplr   = work[31:0];
    // Divide shifts {rem, quo} left first, then trial-subtracts from the new remainder.
    rem_sh = work[62:31];
    quo_sh = {work[30:0], 1'b0};

    // One 33-bit adder serves both modes; divide uses a + ~b + 1 so bit 32
    // is the borrow (set when the trial difference is negative).
    if (div_mode) begin
      add_a = {1'b0, rem_sh};
      add_b = ~{1'b0, operand};
      cin   = 1'b1;
    end else begin
      // The stored carry is always zero after the previous shift; folding it
      // in here keeps the register layout honest at no cost.
      add_a = {work[64], acc};
      add_b = {1'b0, operand};
      cin   = 1'b0;
    end
    sum = add_a + add_b + {32'b0, cin};

    work_nxt = '0;
    if (div_mode) begin
      if (!sum[32]) begin
        work_nxt = {1'b0, sum[31:0], quo_sh[31:1], 1'b1};
      end else begin
        work_nxt = {1'b0, rem_sh, quo_sh};
      end
    end else begin
      // Add (when mplr[0] is set) then shift the whole 65-bit register right.
      if (mplr[0]) begin
        work_nxt = {1'b0, sum, mplr[31:1]};
      end else begin
        work_nxt = {1'b0, 1'b0, acc, mplr[31:1]};
      end
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequential unsigned MULTU/DIVU unit producing the committed HI/LO pair for MFHI/MFLO.
// Latency: 32 cycles from accepted start to hilo/done; one operation per 33 cycles.
// Backpressure: starts are ignored while busy; stall holds an MFHI/MFLO until the result commits.
//
// Ports:
//   clk    in  1  - clock, rising edge
//   reset  in  1  - synchronous, active-high; discards any operation in flight
//   start  in  1  - request strobe, sampled with Signal/dataA/dataB
//   Signal in  6  - funct code (MULTU, DIVU launch; MFHI/MFLO only affect stall)
//   dataA  in  32 - multiplicand / dividend
//   dataB  in  32 - multiplier / divisor
//   hilo   out 64 - committed {HI, LO}, registered
//   busy   out 1  - iteration in progress, registered
//   done   out 1  - one-cycle pulse on commit, registered
//   stall  out 1  - combinational: busy and an MFHI/MFLO is presented
module multdiv_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [63:0] hilo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  md_state_t   state;
  logic [4:0]  cnt;
  logic [64:0] work;
  logic [64:0] work_nxt;
  logic [31:0] operand;
  logic        accept;

  // New operations are taken only when no iteration is running; DONE counts
  // as free so back-to-back operations lose just the single commit cycle.
  always_comb begin
    accept = start && is_md_start(Signal) && ((state == IDLE) || (state == DONE));
  end

  // Depends only on current busy, so the MFHI/MFLO in the DONE cycle passes
  // and reads the freshly committed hilo.
  assign stall = busy && ((Signal == MFHI) || (Signal == MFLO));

  multdiv_step u_step (
    .div_mode (state == DIV),
    .work     (work),
    .operand  (operand),
    .work_nxt (work_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      work    <= '0;
      operand <= '0;
      hilo    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            // Multiply starts with acc=0, mplr=dataA; divide with rem=0, quo=dataA:
            // both are the same bit pattern.
            work    <= {33'b0, dataA};
            operand <= dataB;
            cnt     <= 5'd0;
            busy    <= 1'b1;
            state   <= (Signal == MULTU) ? MUL : DIV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        MUL, DIV: begin
          work <= work_nxt;
          cnt  <= cnt + 5'd1;
          // The counter wrapping 31->0 marks the last of the 32 iterations;
          // commit the step output directly so hilo lands on the same edge.
          if (cnt == 5'd31) begin
            hilo  <= work_nxt[63:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a result scoreboard.
// Expected hilo values are pushed when an operation is launched and popped on done.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_multdiv_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [63:0] hilo;
  logic        busy;
  logic        done;
  logic        stall;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  multdiv_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Signal (Signal),
    .dataA  (dataA),
    .dataB  (dataB),
    .hilo   (hilo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [63:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'bx;
    chk(tag, hilo, e);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
  endtask

  // Launch one operation and follow it to commit. mfhi presents MFHI while
  // busy; poke issues a competing start a few cycles into the operation.
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit mfhi, input bit poke);
    int k;
    int bcyc;
    @(negedge clk);
    start = 1'b1; Signal = fn; dataA = a; dataB = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; Signal = mfhi ? MFHI : 6'd0; dataA = '0; dataB = '0;
    #1;
    k = 0;
    bcyc = 0;
    while (!done && k < 40) begin
      if (busy) bcyc++;
      if (mfhi) chk("stall_busy", {63'b0, stall}, 64'd1);
      if (poke && k == 5) begin
        start = 1'b1; Signal = MULTU; dataA = 32'd3; dataB = 32'd3;
      end
      @(negedge clk);
      if (poke && k == 5) begin
        start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
      end
      #1;
      k++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
    chk("busy_cycles", 64'(bcyc), 64'd32);
    chk("busy_at_done", {63'b0, busy}, 64'd0);
    if (mfhi) chk("stall_done", {63'b0, stall}, 64'd0);
    pop_and_check("result");
    @(negedge clk); #1;
    chk("done_pulse", {63'b0, done}, 64'd0);
    Signal = 6'd0;
  endtask

  initial begin
    int saw_done;
    reset = 1'b1; start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hilo", hilo, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    reset = 1'b0;
    Signal = MFLO;
    #1;
    chk("idle_nostall", {63'b0, stall}, 64'd0);

    run_op(MULTU, 32'd7, 32'd6, 64'd42, 1'b1, 1'b0);
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
    run_op(DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);
    run_op(DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1'b0);

    // Non-launching start must leave the unit idle.
    @(negedge clk);
    start = 1'b1; Signal = ADD; dataA = 32'd1; dataB = 32'd1;
    @(negedge clk);
    start = 1'b0; Signal = 6'd0;
    #1;
    chk("noop_busy", {63'b0, busy}, 64'd0);
    chk("noop_hilo", hilo, {32'd5, 32'hFFFFFFFF});

    // Reset in the middle of a multiply: nothing in flight survives.
    @(negedge clk);
    start = 1'b1; Signal = MULTU; dataA = 32'd123; dataB = 32'd456;
    @(negedge clk);
    start = 1'b0; Signal = 6'd0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_hilo", hilo, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (done || busy) saw_done++;
    end
    chk("midrst_quiet", 64'(saw_done), 64'd0);

    run_op(DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 1'b0);

    // Back-to-back: DIVU launched in the DONE cycle of a MULTU.
    @(negedge clk);
    start = 1'b1; Signal = MULTU; dataA = 32'd3; dataB = 32'd3;
    exp_q.push_back(64'd9);
    @(negedge clk);
    start = 1'b0; Signal = 6'd0;
    #1;
    wait_done();
    pop_and_check("b2b_first");
    start = 1'b1; Signal = DIVU; dataA = 32'd20; dataB = 32'd4;
    exp_q.push_back(64'd5);
    @(negedge clk);
    start = 1'b0; Signal = 6'd0;
    #1;
    chk("b2b_busy", {63'b0, busy}, 64'd1);
    chk("b2b_done_low", {63'b0, done}, 64'd0);
    chk("b2b_hold", hilo, 64'd9);
    wait_done();
    pop_and_check("b2b_second");
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
